ddr_deser: RTL and testbench

Double-data-rate input deserializer: captures a DDR bus on both edges of `clk`, pairs each rising-edge sample with the following falling-edge sample, and packs `PAIRS` consecutive pairs into one wide word. Words are delivered in the `clk` domain over a valid/ready handshake. The block is the receive-side counterpart of the dual-edge output register and sits directly behind DDR input pads, for example on ADC data lanes, feeding FIFO or decimation logic.

---
 rtl/ddr_deser.sv | 100 ++++++++++
 tb/tb_ddr_deser.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ddr_deser.sv
// ddr_deser: double-data-rate input deserializer.
// Captures din on both clk edges and pairs each rising sample with the next
// falling sample. PAIRS consecutive pairs are packed into one word, which is
// delivered on a valid/ready handshake in the rising-edge domain.
// Optional feature: define DDR_DESER_BITSLIP_EN to add the slip_i port, which
// drops one pair per asserted cycle to shift word framing.
module ddr_deser #(
  parameter int DATA_WIDTH = 1,
  parameter int PAIRS      = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DATA_WIDTH-1:0]             din,
  input  logic                              en,
`ifdef DDR_DESER_BITSLIP_EN
  input  logic                              slip_i,
`endif
  output logic [2*PAIRS*DATA_WIDTH-1:0]     word_o,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic                              overflow_o
);

  localparam int PAIR_W = 2 * DATA_WIDTH;
  localparam int WORD_W = PAIRS * PAIR_W;
  localparam int CNT_W  = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PAIRS - 1);

  logic [DATA_WIDTH-1:0] r_p0;
  logic [DATA_WIDTH-1:0] f_p0;
  logic                  en_p0;
  logic [CNT_W-1:0]      cnt;
  logic [WORD_W-1:0]     acc;
  logic [PAIR_W-1:0]     pair;
  logic                  slip;
  logic                  take;
  logic                  done;

  // Drop a pair into its slot of a word; slot 0 is the first-received pair.
  function automatic logic [WORD_W-1:0] place(input logic [WORD_W-1:0] base,
                                              input logic [PAIR_W-1:0] p,
                                              input logic [CNT_W-1:0]  idx);
    logic [WORD_W-1:0] w;
    w = base;
    w[int'(idx)*PAIR_W +: PAIR_W] = p;
    return w;
  endfunction

`ifdef DDR_DESER_BITSLIP_EN
  assign slip = slip_i;
`else
  assign slip = 1'b0;
`endif

  // Rising sample in the low half, falling sample half a cycle later on top.
  assign pair = {f_p0, r_p0};

  // A pair counts only if en was high both when its rising sample was taken
  // and now, so framing restarts on the first pair sampled after en rises.
  assign take = en && en_p0 && !slip;
  assign done = take && (cnt == LAST);

  // Falling-edge capture register.
  always_ff @(negedge clk) begin
    if (!rst_n) f_p0 <= '0;
    else        f_p0 <= din;
  end

  // Stage p0 -> word: rising-edge capture, pair framing and output handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_p0       <= '0;
      en_p0      <= 1'b0;
      cnt        <= '0;
      acc        <= '0;
      word_o     <= '0;
      valid_o    <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      r_p0  <= din;
      en_p0 <= en;

      if (!en) begin
        cnt <= '0;
      end else if (take) begin
        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        acc <= place(acc, pair, cnt);
      end

      if (done && (!valid_o || ready_i)) begin
        word_o  <= place(acc, pair, cnt);
        valid_o <= 1'b1;
      end else begin
        if (done)               overflow_o <= 1'b1;
        if (valid_o && ready_i) valid_o    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ddr_deser.sv
// Directed bench for ddr_deser with DATA_WIDTH=4, PAIRS=2, plus a PAIRS=1
// instance sharing the same inputs.
module tb_ddr_deser;

  logic        clk;
  logic        rst_n;
  logic [3:0]  din;
  logic        en;
  logic        slip;
  logic        ready;
  logic [15:0] word;
  logic        valid;
  logic        overflow;
  logic [7:0]  word1;
  logic        valid1;
  logic        overflow1;

  int n_tests = 0;
  int n_fail  = 0;

  ddr_deser #(.DATA_WIDTH(4), .PAIRS(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .en         (en),
`ifdef DDR_DESER_BITSLIP_EN
    .slip_i     (slip),
`endif
    .word_o     (word),
    .valid_o    (valid),
    .ready_i    (ready),
    .overflow_o (overflow)
  );

  ddr_deser #(.DATA_WIDTH(4), .PAIRS(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .en         (en),
`ifdef DDR_DESER_BITSLIP_EN
    .slip_i     (1'b0),
`endif
    .word_o     (word1),
    .valid_o    (valid1),
    .ready_i    (ready),
    .overflow_o (overflow1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clk cycle: rise value before the rising edge, fall value before the
  // falling edge. Returns 2 time units after the rising edge.
  task automatic cyc(input logic [3:0] rise, input logic [3:0] fall,
                     input logic e, input logic rdy, input logic slp, input logic rn);
    @(negedge clk);
    #2;
    din   = rise;
    en    = e;
    ready = rdy;
    slip  = slp;
    rst_n = rn;
    @(posedge clk);
    #2;
    din = fall;
  endtask

  task automatic do_reset();
    cyc(4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    din = '0; en = 1'b0; slip = 1'b0; ready = 1'b1; rst_n = 1'b0;

    // Reset state
    do_reset();
    chk("rst_word", word, 16'h0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_ovf", overflow, 1'b0);

    // Basic packing
    cyc(4'h1, 4'h2, 1, 1, 0, 1);
    chk("basic_v0", valid, 1'b0);
    cyc(4'h3, 4'h4, 1, 1, 0, 1);
    chk("basic_v1", valid, 1'b0);
    chk("p1_word_a", word1, 8'h21);
    chk("p1_valid_a", valid1, 1'b1);
    cyc(4'h0, 4'h0, 1, 1, 0, 1);
    chk("basic_valid", valid, 1'b1);
    chk("basic_word", word, 16'h4321);
    chk("p1_word_b", word1, 8'h43);
    cyc(4'h0, 4'h0, 0, 1, 0, 1);
    chk("basic_drop", valid, 1'b0);

    // Backpressure and overflow
    do_reset();
    cyc(4'h1, 4'h2, 1, 0, 0, 1);
    cyc(4'h3, 4'h4, 1, 0, 0, 1);
    cyc(4'h5, 4'h6, 1, 0, 0, 1);
    chk("bp_word1", word, 16'h4321);
    cyc(4'h7, 4'h8, 1, 0, 0, 1);
    chk("bp_no_ovf_yet", overflow, 1'b0);
    cyc(4'h0, 4'h0, 1, 0, 0, 1);
    chk("bp_ovf", overflow, 1'b1);
    chk("bp_hold_word", word, 16'h4321);
    chk("bp_hold_valid", valid, 1'b1);
    cyc(4'h0, 4'h0, 0, 1, 0, 1);
    chk("bp_xfer_drop", valid, 1'b0);
    chk("bp_ovf_sticky", overflow, 1'b1);

    // Back-to-back with ready high throughout
    do_reset();
    cyc(4'h1, 4'h2, 1, 1, 0, 1);
    cyc(4'h3, 4'h4, 1, 1, 0, 1);
    cyc(4'h5, 4'h6, 1, 1, 0, 1);
    chk("b2b_word1", word, 16'h4321);
    cyc(4'h7, 4'h8, 1, 1, 0, 1);
    chk("b2b_gap", valid, 1'b0);
    cyc(4'h0, 4'h0, 1, 1, 0, 1);
    chk("b2b_word2", word, 16'h8765);
    chk("b2b_valid2", valid, 1'b1);
    chk("b2b_ovf", overflow, 1'b0);

    // Completion on the same edge as a transfer
    do_reset();
    cyc(4'h1, 4'h2, 1, 0, 0, 1);
    cyc(4'h3, 4'h4, 1, 0, 0, 1);
    cyc(4'h5, 4'h6, 1, 0, 0, 1);
    cyc(4'h7, 4'h8, 1, 0, 0, 1);
    cyc(4'h0, 4'h0, 1, 1, 0, 1);
    chk("same_edge_word", word, 16'h8765);
    chk("same_edge_valid", valid, 1'b1);
    chk("same_edge_ovf", overflow, 1'b0);

    // Enable abort
    do_reset();
    cyc(4'h1, 4'h2, 1, 1, 0, 1);
    cyc(4'h0, 4'h0, 0, 1, 0, 1);
    cyc(4'h5, 4'h6, 1, 1, 0, 1);
    chk("abort_v0", valid, 1'b0);
    cyc(4'h7, 4'h8, 1, 1, 0, 1);
    chk("abort_v1", valid, 1'b0);
    cyc(4'h0, 4'h0, 1, 1, 0, 1);
    chk("abort_word", word, 16'h8765);
    chk("abort_valid", valid, 1'b1);
    cyc(4'h0, 4'h0, 0, 1, 0, 1);

    // Reset mid-word with a pending word and overflow set
    do_reset();
    cyc(4'h1, 4'h2, 1, 0, 0, 1);
    cyc(4'h3, 4'h4, 1, 0, 0, 1);
    cyc(4'h5, 4'h6, 1, 0, 0, 1);
    cyc(4'h7, 4'h8, 1, 0, 0, 1);
    cyc(4'h1, 4'h2, 1, 0, 0, 1);
    chk("pre_rst_ovf", overflow, 1'b1);
    cyc(4'h3, 4'h4, 1, 1, 0, 0);
    chk("mid_rst_word", word, 16'h0);
    chk("mid_rst_valid", valid, 1'b0);
    chk("mid_rst_ovf", overflow, 1'b0);
    cyc(4'h9, 4'hA, 1, 1, 0, 1);
    cyc(4'hB, 4'hC, 1, 1, 0, 1);
    chk("post_rst_v", valid, 1'b0);
    cyc(4'h0, 4'h0, 1, 1, 0, 1);
    chk("post_rst_word", word, 16'hCBA9);
    chk("post_rst_valid", valid, 1'b1);

`ifdef DDR_DESER_BITSLIP_EN
    // Bitslip shifts framing by one pair
    do_reset();
    cyc(4'h1, 4'h2, 1, 1, 0, 1);
    cyc(4'h3, 4'h4, 1, 1, 1, 1);
    cyc(4'h5, 4'h6, 1, 1, 0, 1);
    chk("slip_v", valid, 1'b0);
    cyc(4'h7, 4'h8, 1, 1, 0, 1);
    chk("slip_word", word, 16'h6543);
    chk("slip_valid", valid, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
